// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the L1I/L1D memory-port arbiter.
// Round-robin conflict resolution is selected with CACHE_ARB_RR_EN.
package cache_arb_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM, conflict counter and (with CACHE_ARB_RR_EN) last-grant register.
// Default build: fixed priority, D wins every conflict.
module cache_arbiter_control
    import cache_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        d_req,
    input  logic        pmem_resp,
    input  logic        arb_conflict_clear,
    output arb_state_e  state,
    output logic [31:0] arb_conflict_count
);

    arb_state_e  state_next;
    grant_e      conflict_grant;
    logic        conflict;
    logic [31:0] conflict_count;
    logic [31:0] count_next;

    assign conflict = (state == IDLE) & i_req & d_req;

`ifdef CACHE_ARB_RR_EN
    grant_e last_grant;
    grant_e last_grant_next;

    // Reset value GRANT_I hands the first conflict to D.
    assign conflict_grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_I;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant;
        if (state == IDLE && state_next == SERVE_I) begin
            last_grant_next = GRANT_I;
        end else if (state == IDLE && state_next == SERVE_D) begin
            last_grant_next = GRANT_D;
        end
    end
`else
    assign conflict_grant = GRANT_D;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    conflict: begin
                        state_next = (conflict_grant == GRANT_D) ? SERVE_D : SERVE_I;
                    end
                    i_req & ~d_req: state_next = SERVE_I;
                    d_req & ~i_req: state_next = SERVE_D;
                    default:        state_next = IDLE;
                endcase
            end
            // Completion always passes through IDLE so a held request is not reissued.
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = conflict_count;
        if (arb_conflict_clear) begin
            count_next = '0;
        end else if (conflict && conflict_count != 32'hFFFF_FFFF) begin
            count_next = conflict_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            conflict_count <= '0;
        end else begin
            state          <= state_next;
            conflict_count <= count_next;
        end
    end

    assign arb_conflict_count = conflict_count;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one memory port between L1I fills and L1D fills/writebacks.
// Define CACHE_ARB_RR_EN for round-robin conflicts; default is D priority.
module cache_arbiter
    import cache_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    input  logic                  arb_conflict_clear,
    output logic [31:0]           arb_conflict_count
);

    arb_state_e state;
    logic       i_req;
    logic       d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    cache_arbiter_control u_ctrl (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req              (i_req),
        .d_req              (d_req),
        .pmem_resp          (pmem_resp),
        .arb_conflict_clear (arb_conflict_clear),
        .state              (state),
        .arb_conflict_count (arb_conflict_count)
    );

    // Memory port follows the live requester inputs; nothing is latched.
    always_comb begin
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        if (rst_n) begin
            unique case (state)
                SERVE_I: begin
                    pmem_address = i_address;
                    pmem_read    = 1'b1;
                    i_resp       = pmem_resp;
                end
                SERVE_D: begin
                    pmem_address = d_address;
                    pmem_read    = d_read & ~d_write;
                    pmem_write   = d_write;
                    pmem_wdata   = d_wdata;
                    d_resp       = pmem_resp;
                end
                default: begin
                    pmem_address = '0;
                end
            endcase
        end
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed plus randomized bench for cache_arbiter against a transaction-level model.
// Honors CACHE_ARB_RR_EN for the expected conflict winner.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_address;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         arb_conflict_clear;
    logic [31:0]  arb_conflict_count;

    int checks = 0;
    int errors = 0;

    // Model: who owns the memory port (0 none, 1 I, 2 D), conflict count.
    int          m_owner;
    logic [31:0] m_count;
`ifdef CACHE_ARB_RR_EN
    bit          m_last_d;
`endif
    bit          i_done;
    bit          d_done;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_address          (i_address),
        .i_read             (i_read),
        .i_rdata            (i_rdata),
        .i_resp             (i_resp),
        .d_address          (d_address),
        .d_read             (d_read),
        .d_write            (d_write),
        .d_wdata            (d_wdata),
        .d_rdata            (d_rdata),
        .d_resp             (d_resp),
        .pmem_address       (pmem_address),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp),
        .arb_conflict_clear (arb_conflict_clear),
        .arb_conflict_count (arb_conflict_count)
    );

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0]  e_addr;
        logic [255:0] e_wdata;
        logic         e_rd;
        logic         e_wr;
        logic         e_ir;
        logic         e_dr;
        e_addr  = '0;
        e_wdata = '0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        e_ir    = 1'b0;
        e_dr    = 1'b0;
        if (rst_n && m_owner == 1) begin
            e_addr = i_address;
            e_rd   = 1'b1;
            e_ir   = pmem_resp;
        end else if (rst_n && m_owner == 2) begin
            e_addr  = d_address;
            e_wdata = d_wdata;
            e_rd    = d_read & ~d_write;
            e_wr    = d_write;
            e_dr    = pmem_resp;
        end
        check("pmem_address", pmem_address, e_addr);
        check("pmem_read", pmem_read, e_rd);
        check("pmem_write", pmem_write, e_wr);
        check("pmem_wdata", pmem_wdata, e_wdata);
        check("i_resp", i_resp, e_ir);
        check("d_resp", d_resp, e_dr);
        check("i_rdata", i_rdata, pmem_rdata);
        check("d_rdata", d_rdata, pmem_rdata);
        check("conflict_count", arb_conflict_count, m_count);
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    // Apply the rules for the clock edge about to happen, then pass it.
    task automatic advance();
        bit ip;
        bit dp;
        ip     = i_read;
        dp     = d_read | d_write;
        i_done = rst_n && m_owner == 1 && pmem_resp;
        d_done = rst_n && m_owner == 2 && pmem_resp;
        if (!rst_n) begin
            m_owner = 0;
            m_count = '0;
`ifdef CACHE_ARB_RR_EN
            m_last_d = 1'b0;
`endif
        end else begin
            if (arb_conflict_clear) begin
                m_count = '0;
            end else if (m_owner == 0 && ip && dp && m_count != 32'hFFFF_FFFF) begin
                m_count = m_count + 32'd1;
            end
            if (m_owner == 0) begin
                if (ip && dp) begin
`ifdef CACHE_ARB_RR_EN
                    m_owner = m_last_d ? 1 : 2;
`else
                    m_owner = 2;
`endif
                end else if (ip) begin
                    m_owner = 1;
                end else if (dp) begin
                    m_owner = 2;
                end
`ifdef CACHE_ARB_RR_EN
                if (m_owner != 0) m_last_d = (m_owner == 2);
`endif
            end else if (pmem_resp) begin
                m_owner = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_g [3];
        bit          i_pend;
        bit          d_pend;
        int          op;

        rst_n = 1'b0;
        i_address = '0;
        i_read = 1'b0;
        d_address = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_wdata = '0;
        pmem_rdata = {8{32'hC0DE_0001}};
        pmem_resp = 1'b0;
        arb_conflict_clear = 1'b0;
        m_owner = 0;
        m_count = '0;
`ifdef CACHE_ARB_RR_EN
        m_last_d = 1'b0;
`endif
        @(posedge clk);
        #1;
        settle();
        check("reset_count", arb_conflict_count, 32'd0);
        advance();
        rst_n = 1'b1;

        // Lone I request
        i_read = 1'b1;
        i_address = 32'h0000_1000;
        settle();
        check("lone_i_c0_read", pmem_read, 1'b0);
        advance();
        settle();
        check("lone_i_c1_read", pmem_read, 1'b1);
        check("lone_i_c1_addr", pmem_address, 32'h0000_1000);
        advance();
        repeat (3) begin
            settle();
            advance();
        end
        pmem_resp = 1'b1;
        settle();
        check("lone_i_c5_iresp", i_resp, 1'b1);
        check("lone_i_c5_dresp", d_resp, 1'b0);
        advance();
        pmem_resp = 1'b0;
        i_read = 1'b0;
        settle();
        check("lone_i_c6_idle", pmem_read, 1'b0);
        advance();

        // Stray response while idle
        pmem_resp = 1'b1;
        settle();
        check("stray_iresp", i_resp, 1'b0);
        check("stray_dresp", d_resp, 1'b0);
        advance();
        pmem_resp = 1'b0;
        settle();
        check("stray_idle", pmem_read | pmem_write, 1'b0);
        advance();

        // Single conflict: D first, then I
        i_read = 1'b1;
        i_address = 32'h0000_3000;
        d_write = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata = {8{32'hA5A5_5A5A}};
        settle();
        advance();
        pmem_resp = 1'b1;
        settle();
        check("conf_c1_write", pmem_write, 1'b1);
        check("conf_c1_addr", pmem_address, 32'h0000_2000);
        check("conf_c1_wdata", pmem_wdata, {8{32'hA5A5_5A5A}});
        advance();
        pmem_resp = 1'b0;
        d_write = 1'b0;
        settle();
        check("conf_gap_idle", pmem_read | pmem_write, 1'b0);
        advance();
        pmem_resp = 1'b1;
        settle();
        check("conf_i_read", pmem_read, 1'b1);
        check("conf_i_addr", pmem_address, 32'h0000_3000);
        check("conf_count1", arb_conflict_count, 32'd1);
        advance();
        pmem_resp = 1'b0;
        i_read = 1'b0;

        // Back-to-back conflicts with both requesters re-requesting
`ifdef CACHE_ARB_RR_EN
        exp_g = '{32'h0000_2000, 32'h0000_3000, 32'h0000_2000};
`else
        exp_g = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
`endif
        i_read = 1'b1;
        d_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            advance();
            pmem_resp = 1'b1;
            settle();
            check($sformatf("b2b_grant%0d", k), pmem_address, exp_g[k]);
            advance();
            pmem_resp = 1'b0;
        end
        i_read = 1'b0;
        d_write = 1'b0;
        settle();
        advance();

        // Reset in the middle of a D write
        d_write = 1'b1;
        d_address = 32'h0000_4000;
        settle();
        advance();
        settle();
        check("rst_pre_write", pmem_write, 1'b1);
        rst_n = 1'b0;
        advance();
        settle();
        check("rst_write", pmem_write, 1'b0);
        check("rst_addr", pmem_address, 32'd0);
        check("rst_count", arb_conflict_count, 32'd0);
        rst_n = 1'b1;
        d_write = 1'b0;
        advance();
        settle();
        check("rst_after_idle", pmem_read | pmem_write, 1'b0);
        advance();

        // Saturation and clear
        i_read = 1'b1;
        i_address = 32'h0000_6000;
        d_read = 1'b1;
        d_address = 32'h0000_5000;
        force dut.u_ctrl.conflict_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        settle();
        check("sat_forced", arb_conflict_count, 32'hFFFF_FFFF);
        advance();
        release dut.u_ctrl.conflict_count;
        pmem_resp = 1'b1;
        settle();
        check("sat_hold", arb_conflict_count, 32'hFFFF_FFFF);
        advance();
        pmem_resp = 1'b0;
        arb_conflict_clear = 1'b1;
        settle();
        advance();
        arb_conflict_clear = 1'b0;
        settle();
        check("clear_zero", arb_conflict_count, 32'd0);

        // Randomized traffic
        i_pend = i_read;
        d_pend = d_read | d_write;
        repeat (4000) begin
            advance();
            rst_n = ($urandom_range(199) != 0);
            if (i_done || !rst_n) i_pend = 1'b0;
            if (d_done || !rst_n) d_pend = 1'b0;
            if (!i_pend && rst_n && $urandom_range(1) == 1) begin
                i_pend = 1'b1;
                i_address = $urandom;
            end
            i_read = i_pend;
            if (!d_pend && rst_n && $urandom_range(1) == 1) begin
                d_pend = 1'b1;
                d_address = $urandom;
                for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
                op = $urandom_range(2);
                d_read = (op != 1);
                d_write = (op != 0);
            end
            if (!d_pend) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end
            pmem_resp = (m_owner != 0) ? ($urandom_range(2) == 0)
                                       : ($urandom_range(7) == 0);
            for (int k = 0; k < 8; k++) pmem_rdata[k*32 +: 32] = $urandom;
            arb_conflict_clear = ($urandom_range(63) == 0);
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
